// File: rtl/uart_pkg.sv
// Shared UART constants and the receive FSM state type.
// Used by uart_rx and by uart_clock_divider users.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous rx pin into the clk domain.
// Turns the level-toggling oversampling clock into a one-clk tick.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    input  logic uart_sampling_clk,
    output logic rx_s,
    output logic tick
);

    logic rx_meta;
    logic samp_q;

    // Both rx flops preset high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            samp_q  <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            samp_q  <= uart_sampling_clk;
        end
    end

    assign tick = uart_sampling_clk & ~samp_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled, bit-centred sampling, with a byte
// output handshake and one-clk framing/overrun error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_sampling_clk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic rx_s;
    logic tick;

    uart_rx_sync u_sync (
        .clk               (clk),
        .rst_n             (rst_n),
        .rx                (rx),
        .uart_sampling_clk (uart_sampling_clk),
        .rx_s              (rx_s),
        .tick              (tick)
    );

    uart_rx_state_t       state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 frame_ok;
    logic                 frame_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n = START;
                        cnt_n   = '0;
                    end
                end
                START: begin
                    // Re-check the line half a bit in; a high line was a glitch.
                    if (cnt == CNT_MID) begin
                        cnt_n = '0;
                        if (!rx_s) begin
                            state_n   = DATA;
                            bit_idx_n = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
                        cnt_n     = '0;
                        bit_idx_n = bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST) begin
                            state_n = STOP;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        state_n   = IDLE;
                        cnt_n     = '0;
                        frame_ok  = rx_s;
                        frame_bad = ~rx_s;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Handshake: a byte transfers on any clk edge where rx_valid and rx_ready
    // are both high; rx_valid/rx_data then hold until that transfer happens,
    // and a new frame may replace the byte in the same cycle it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            framing_error <= frame_bad;
            overrun_error <= 1'b0;
            if (frame_ok) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun_error <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 200 MHz with a 16x sampling clock of
// 14 clk per tick (224 clk per bit).
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int DB      = 8;
    localparam int BIT_CLK = 224;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          uart_sampling_clk = 1'b0;
    logic          rx = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          framing_error;
    logic          overrun_error;
    logic          rx_busy;

    uart_rx dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .uart_sampling_clk (uart_sampling_clk),
        .rx                (rx),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_ready          (rx_ready),
        .framing_error     (framing_error),
        .overrun_error     (overrun_error),
        .rx_busy           (rx_busy)
    );

    // clock/reset block: 5 ns clk, sampling clk toggles every 7 clk
    always #2.5 clk = ~clk;
    always #35 uart_sampling_clk = ~uart_sampling_clk;

    int n_total = 0;
    int n_bad   = 0;
    int fe_cnt  = 0;
    int ov_cnt  = 0;
    int rx_count = 0;
    logic [DB-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard: every accepted byte must match the head of exp_q
    always @(negedge clk) begin
        if (rst_n) begin
            if (framing_error) fe_cnt++;
            if (overrun_error) ov_cnt++;
            if (rx_valid && rx_ready) begin
                rx_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte_qsize", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // driver tasks
    task automatic send_bit(input logic v);
        rx = v;
        repeat (BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    int fe0, ov0, cnt0;

    initial begin
        // reset state
        #1;
        check("rst_data", 32'(rx_data), 32'h0);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_fe", 32'(framing_error), 32'h0);
        check("rst_ov", 32'(overrun_error), 32'h0);
        check("rst_busy", 32'(rx_busy), 32'h0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_bits(1);

        // 0xA5 with ready high
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_drain("a5_drain", 4 * BIT_CLK);
        idle_bits(1);
        check("a5_count", 32'(rx_count), 32'd1);
        check("a5_fe", 32'(fe_cnt), 32'd0);
        check("a5_ov", 32'(ov_cnt), 32'd0);
        check("a5_valid_cleared", 32'(rx_valid), 32'd0);

        // false start: low for 3 ticks
        rx = 1'b0;
        repeat (3 * 14) @(posedge clk);
        #1 rx = 1'b1;
        idle_bits(2);
        check("fs_valid", 32'(rx_valid), 32'd0);
        check("fs_busy", 32'(rx_busy), 32'd0);
        check("fs_fe", 32'(fe_cnt), 32'd0);
        check("fs_count", 32'(rx_count), 32'd1);

        // 0x3C with bad stop bit, then 0x55
        send_frame(8'h3C, 1'b0);
        idle_bits(2);
        check("fe_pulse_cycles", 32'(fe_cnt), 32'd1);
        check("fe_valid", 32'(rx_valid), 32'd0);
        check("fe_count", 32'(rx_count), 32'd1);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        wait_drain("55_drain", 4 * BIT_CLK);
        idle_bits(1);
        check("55_count", 32'(rx_count), 32'd2);

        // back-to-back 0x00, 0xFF
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_drain("b2b_drain", 4 * BIT_CLK);
        idle_bits(1);
        check("b2b_count", 32'(rx_count), 32'd4);
        check("b2b_fe", 32'(fe_cnt), 32'd1);
        check("b2b_ov", 32'(ov_cnt), 32'd0);

        // overrun: ready low, 0x11 then 0x22
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        idle_bits(1);
        check("ovr_valid_held", 32'(rx_valid), 32'd1);
        check("ovr_data_11", 32'(rx_data), 32'h11);
        send_frame(8'h22, 1'b1);
        idle_bits(1);
        check("ovr_pulse_cycles", 32'(ov_cnt), 32'd1);
        check("ovr_data_kept", 32'(rx_data), 32'h11);
        check("ovr_valid_still", 32'(rx_valid), 32'd1);
        exp_q.push_back(8'h11);
        rx_ready = 1'b1;
        wait_drain("ovr_drain", 8);
        @(posedge clk);
        #1;
        check("ovr_valid_cleared", 32'(rx_valid), 32'd0);
        check("ovr_data_not_cleared", 32'(rx_data), 32'h11);
        idle_bits(1);

        // reset during data bit 4, then 0xC3
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b0;
        repeat (BIT_CLK / 2) @(posedge clk);
        #1;
        check("mid_busy", 32'(rx_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_data", 32'(rx_data), 32'h0);
        check("mrst_valid", 32'(rx_valid), 32'd0);
        check("mrst_busy", 32'(rx_busy), 32'd0);
        check("mrst_fe", 32'(framing_error), 32'd0);
        check("mrst_ov", 32'(overrun_error), 32'd0);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_bits(2);
        cnt0 = rx_count;
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        wait_drain("c3_drain", 4 * BIT_CLK);
        idle_bits(1);
        check("c3_count", 32'(rx_count - cnt0), 32'd1);
        check("c3_fe", 32'(fe_cnt - fe0), 32'd0);
        check("c3_ov", 32'(ov_cnt - ov0), 32'd0);

        // final report
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
